alu_lp_pipe: RTL and testbench
==============================

# alu_lp_pipe

Parametrised low-power pipelined ALU, the next-generation replacement for the fixed 16-bit clock-enabled ALU. It takes operands and an opcode over a valid/ready handshake, registers them in an isolation stage, computes, and presents a registered result with four status flags. A global enable freezes the whole pipeline, so no register toggles while it is low. An optional idle detector raises a sleep hint for the power controller.

## Interface
- `WIDTH`, 16: operand/result width, ≥4.
- `IDLE_CYCLES`, 16: consecutive idle cycles before `sleep` asserts, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `en` in 1: pipeline enable; 0 freezes all state.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: operand beat accepted when `in_valid & in_ready` at a rising edge.
- `a`, `b` in WIDTH: operands.
- `s` in 4: opcode.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `yout` out WIDTH: result.
- `carry`, `zero`, `neg`, `ovf` out 1: flags.
- `sleep` out 1: idle hint.

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a−b; 2 INC a+1; 3 DEC a−1; 4 AND; 5 OR; 6 XOR; 7 NOT a; 8 SHL a by 1; 9 SHR a by 1 (logical); 10 SAR a by 1; 11 ROL a by 1; 12 ROR a by 1; 13 PASS a; 14 PASS b; 15 SLT: result is 1 if signed a<b, else 0.
- All arithmetic is modulo 2^WIDTH.
- `carry` by opcode:
  - ADD/INC: carry-out.
  - SUB/DEC: borrow, i.e. 1 when unsigned a < subtrahend.
  - Shifts and rotates: the bit shifted or rotated out.
  - All other opcodes: 0.
- `ovf`: two's-complement overflow for ADD/SUB/INC/DEC; 0 for all other opcodes.
- `zero` = (yout==0). `neg` = yout[WIDTH-1].
- Stage 1 (operand isolation):
  - `a`, `b`, `s` are captured only on an accepted beat; otherwise they hold, so the datapath sees no toggles.
  - `s1_valid` marks stage 1 occupied.
- Stage 2: result and flags are registered from the stage-1 values. `out_valid` = s2 occupied.
- Advance rules:
  - `adv2 = en & s1_valid & (!out_valid | out_ready)`.
  - `in_ready = en & (!s1_valid | adv2)`.
- `out_valid` clears when `en & out_ready & !adv2`.
- Idle detector:
  - A counter increments each `en` cycle in which `in_valid=0`, `s1_valid=0` and `out_valid=0`.
  - It saturates at IDLE_CYCLES. `sleep` = (count==IDLE_CYCLES).
  - Any cycle where `in_valid=1` or the pipeline is occupied resets the count to 0 at the next edge.
  - `en=0` holds the count.

## Timing
- Reset values: `in_ready` 0 (it is 1 whenever `en=1`, including the first cycle after reset); `out_valid` 0; `yout` 0; all flags 0; `sleep` 0; idle count 0; `s1_valid` 0.
- Latency: a beat accepted at edge k shows on `yout`/flags with `out_valid=1` after edge k+1, provided `en` stays high.
- Throughput: 1 beat/cycle with `out_ready=1`.
- Backpressure (`out_ready=0`, `out_valid=1`):
  - `yout` and flags hold stable.
  - Stage 1 fills; then `in_ready=0`.
  - Maximum occupancy is 2 beats; no beat is dropped or duplicated.
- Full pipe with `out_ready=1`: accept, advance and output happen in the same cycle.
- `en=0`:
  - `in_ready=0` combinationally.
  - No register changes.
  - `out_valid`/`yout` hold and stay visible. Downstream must not count a transfer while `en=0`; the handshake is defined only when `en=1`.
- `rst` mid-operation: all in-flight beats are discarded and outputs return to reset values at that edge. `rst` overrides `en`.
- `sleep` rises at the edge that brings the count to IDLE_CYCLES. It falls at the edge after `in_valid` is first seen high.

## Configuration
- `ALU_LP_SLEEP_EN`:
  - Defined: the idle counter and the `sleep` logic are built as specified.
  - Undefined: no counter is instantiated and `sleep` is tied to 0. All other behaviour is identical.

## Test plan
- WIDTH=16, no stall: ADD a=16'hFFFF b=16'h0001 -> one cycle after accept, yout=0, carry=1, zero=1, ovf=0. Then ADD 16'h7FFF+16'h0001 -> yout=16'h8000, ovf=1, neg=1.
- SUB 16'h0003−16'h0005 -> yout=16'hFFFE, carry=1, neg=1. SLT a=16'h8000 b=16'h0001 -> yout=1. SAR 16'h8001 -> yout=16'hC000, carry=1.
- Backpressure: out_ready=0, send 3 beats back-to-back -> 2 accepted, in_ready=0 on the 3rd, yout stable. Raise out_ready -> the 3 results emerge in order, no loss.
- en=0 for 5 cycles with a full pipe and toggling a/b/s -> no output, flag or state change. Resume -> results unchanged and in order.
- rst asserted with 2 beats in flight -> next cycle out_valid=0, yout=0. The first accepted beat after reset appears with 1-cycle latency.
- With ALU_LP_SLEEP_EN, IDLE_CYCLES=4: idle after reset -> sleep=1 after the 4th idle edge. Assert in_valid -> sleep=0 after the next edge. Without the macro, sleep stays 0 throughout.

Source files
------------

// File: rtl/alu_lp_pipe_if.sv
// Operand/result handshake bundle for alu_lp_pipe.
// master: upstream producer plus downstream consumer; slave: the ALU itself.
interface alu_lp_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] yout;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, a, b, s, out_ready,
    input  in_ready, out_valid, yout, carry, zero, neg, ovf
  );

  modport slave (
    input  in_valid, a, b, s, out_ready,
    output in_ready, out_valid, yout, carry, zero, neg, ovf
  );
endinterface

// File: rtl/alu_lp_pipe.sv
// alu_lp_pipe: two-stage ALU with operand isolation and a global freeze enable; ALU_LP_SLEEP_EN adds an idle sleep hint.
// Latency: result valid one edge after accept. Backpressure: output holds, stage 1 fills, then in_ready drops.
module alu_lp_pipe #(
  parameter int WIDTH       = 16,
  parameter int IDLE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  alu_lp_pipe_if.slave bus,
  output logic         sleep
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SAR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_PSA  = 4'd13;
  localparam logic [3:0] OP_PSB  = 4'd14;
  localparam logic [3:0] OP_SLT  = 4'd15;

  // Stage 1: isolation registers, loaded only on an accepted beat.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;

  // Stage 2: registered result and flags.
  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic             carry_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;

  logic in_ready_w;
  logic accept;
  logic adv2;

  assign adv2       = en & s1_valid & (~out_valid_q | bus.out_ready);
  assign in_ready_w = en & (~s1_valid | adv2);
  assign accept     = bus.in_valid & in_ready_w;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.yout      = y_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;

  // One shared adder and subtractor; INC/DEC reuse them with a constant 1.
  logic             use_one;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt;

  assign use_one = (s1_op == OP_INC) | (s1_op == OP_DEC);
  assign opnd_b  = use_one ? WIDTH'(1) : s1_b;
  assign add_ext = {1'b0, s1_a} + {1'b0, opnd_b};
  assign sub_ext = {1'b0, s1_a} - {1'b0, opnd_b};
  assign add_ovf = (s1_a[MSB] == opnd_b[MSB]) & (add_ext[MSB] != s1_a[MSB]);
  assign sub_ovf = (s1_a[MSB] != opnd_b[MSB]) & (sub_ext[MSB] != s1_a[MSB]);
  assign slt     = $signed(s1_a) < $signed(s1_b);

  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (s1_op)
      OP_ADD, OP_INC: begin
        alu_y = add_ext[MSB:0];
        alu_c = add_ext[WIDTH];
        alu_v = add_ovf;
      end
      OP_SUB, OP_DEC: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        alu_y = sub_ext[MSB:0];
        alu_c = sub_ext[WIDTH];
        alu_v = sub_ovf;
      end
      OP_AND: alu_y = s1_a & s1_b;
      OP_OR:  alu_y = s1_a | s1_b;
      OP_XOR: alu_y = s1_a ^ s1_b;
      OP_NOT: alu_y = ~s1_a;
      OP_SHL: begin
        alu_y = {s1_a[MSB-1:0], 1'b0};
        alu_c = s1_a[MSB];
      end
      OP_SHR: begin
        alu_y = {1'b0, s1_a[MSB:1]};
        alu_c = s1_a[0];
      end
      OP_SAR: begin
        alu_y = {s1_a[MSB], s1_a[MSB:1]};
        alu_c = s1_a[0];
      end
      OP_ROL: begin
        alu_y = {s1_a[MSB-1:0], s1_a[MSB]};
        alu_c = s1_a[MSB];
      end
      OP_ROR: begin
        alu_y = {s1_a[0], s1_a[MSB:1]};
        alu_c = s1_a[0];
      end
      OP_PSA: alu_y = s1_a;
      OP_PSB: alu_y = s1_b;
      OP_SLT: alu_y = {{(WIDTH-1){1'b0}}, slt};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_op       <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      if (accept) begin
        s1_a  <= bus.a;
        s1_b  <= bus.b;
        s1_op <= bus.s;
      end
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end

      if (adv2) begin
        out_valid_q <= 1'b1;
        y_q         <= alu_y;
        carry_q     <= alu_c;
        zero_q      <= (alu_y == '0);
        neg_q       <= alu_y[MSB];
        ovf_q       <= alu_v;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_LP_SLEEP_EN
  localparam int             CW       = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0]  IDLE_MAX = CW'(IDLE_CYCLES);

  logic [CW-1:0] idle_cnt;
  logic          idle;

  assign idle = ~bus.in_valid & ~s1_valid & ~out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (en) begin
      if (!idle) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

  assign sleep = (idle_cnt == IDLE_MAX);
`else
  // IDLE_CYCLES stays referenced so the parameter list is identical in both builds.
  assign sleep = 1'b0 & (IDLE_CYCLES > 0);
`endif

endmodule

// File: tb/tb_alu_lp_pipe.sv
// Scoreboard bench for alu_lp_pipe: expected results queued on accept, compared on each output transfer.
module tb_alu_lp_pipe;
  localparam int W    = 16;
  localparam int IDLE = 4;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         z;
    logic         n;
    logic         o;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic sleep;

  int   tests = 0;
  int   fails = 0;
  res_t sb[$];
  res_t mon_exp;
  res_t mon_got;

  always #5 clk = ~clk;

  alu_lp_pipe_if #(.WIDTH(W)) bus ();

  alu_lp_pipe #(.WIDTH(W), .IDLE_CYCLES(IDLE)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bus  (bus),
    .sleep(sleep)
  );

  // Reference model written with plain integer arithmetic.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
    int ua, ub, sa, sbv, r, sr;
    logic [W-1:0] y;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sbv = int'($signed(b));
    r = 0; sr = 0; c = 1'b0; o = 1'b0;
    case (s)
      4'd0:  begin r = ua + ub; sr = sa + sbv; c = (r > 65535); o = (sr > 32767) || (sr < -32768); end
      4'd1:  begin r = ua - ub; sr = sa - sbv; c = (ua < ub);   o = (sr > 32767) || (sr < -32768); end
      4'd2:  begin r = ua + 1;  sr = sa + 1;   c = (r > 65535); o = (sr > 32767); end
      4'd3:  begin r = ua - 1;  sr = sa - 1;   c = (ua < 1);    o = (sr < -32768); end
      4'd4:  r = ua & ub;
      4'd5:  r = ua | ub;
      4'd6:  r = ua ^ ub;
      4'd7:  r = ~ua;
      4'd8:  begin r = ua * 2; c = (ua >= 32768); end
      4'd9:  begin r = ua / 2; c = (ua % 2 == 1); end
      4'd10: begin r = ua / 2 + ((ua >= 32768) ? 32768 : 0); c = (ua % 2 == 1); end
      4'd11: begin r = ua * 2 + ua / 32768; c = (ua >= 32768); end
      4'd12: begin r = ua / 2 + (ua % 2) * 32768; c = (ua % 2 == 1); end
      4'd13: r = ua;
      4'd14: r = ub;
      default: r = (sa < sbv) ? 1 : 0;
    endcase
    y = r[W-1:0];
    return {y, c, (y == '0), y[W-1], o};
  endfunction

  function automatic res_t observed();
    return {bus.yout, bus.carry, bus.zero, bus.neg, bus.ovf};
  endfunction

  // Scoreboard monitor: sampled mid-cycle, so it sees what the next rising edge will commit.
  always @(negedge clk) begin
    if (!rst && en) begin
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_spurious: output %h with no beat outstanding", observed());
        end else begin
          mon_exp = sb.pop_front();
          mon_got = observed();
          if (mon_got !== mon_exp) begin
            fails++;
            $display("FAIL sb_result: got %h want %h", mon_got, mon_exp);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.a, bus.b, bus.s));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.s = s;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.s = '0;
    repeat (3) tick();
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (observed() !== '0) begin fails++; $display("FAIL rst_outputs: got %h want 0", observed()); end
    tests++; if (sleep !== 1'b0) begin fails++; $display("FAIL rst_sleep: got %b want 0", sleep); end
    en = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_en: got %b want 1", bus.in_ready); end
    rst = 1'b0;
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_release_valid: got %b want 0", bus.out_valid); end
  endtask

  logic [W-1:0] tv_a [14] = '{16'hFFFF, 16'h7FFF, 16'h0003, 16'h8000, 16'h8001, 16'h8001, 16'h0001,
                              16'h8000, 16'hFFFF, 16'hAAAA, 16'h0000, 16'h1234, 16'h8001, 16'h4001};
  logic [W-1:0] tv_b [14] = '{16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'hAAAA, 16'h0000, 16'h5678, 16'h0000, 16'h0000};
  logic [3:0]   tv_s [14] = '{4'd0, 4'd0, 4'd1, 4'd15, 4'd10, 4'd11, 4'd12,
                              4'd3, 4'd2, 4'd6, 4'd7, 4'd14, 4'd9, 4'd8};
  // Expected {yout, carry, zero, neg, ovf}, worked out by hand.
  res_t         tv_r [14] = '{{16'h0000, 4'b1100}, {16'h8000, 4'b0011}, {16'hFFFE, 4'b1010},
                              {16'h0001, 4'b0000}, {16'hC000, 4'b1010}, {16'h0003, 4'b1000},
                              {16'h8000, 4'b1010}, {16'h7FFF, 4'b0001}, {16'h0000, 4'b1100},
                              {16'h0000, 4'b0100}, {16'hFFFF, 4'b0010}, {16'h5678, 4'b0000},
                              {16'h4000, 4'b1000}, {16'h8002, 4'b0010}};

  task automatic test_vectors();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_beat(tv_a[i], tv_b[i], tv_s[i]);
      #1;
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL vec_ready[%0d]: got %b want 1", i, bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL vec_latency_early[%0d]: out_valid %b want 0", i, bus.out_valid); end
      tick();
      tests++;
      if (bus.out_valid !== 1'b1 || observed() !== tv_r[i]) begin
        fails++;
        $display("FAIL vec_result[%0d]: got valid %b %h want valid 1 %h", i, bus.out_valid, observed(), tv_r[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_beat(W'($urandom), W'($urandom), 4'($urandom));
      #1;
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.in_ready); end
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_drain: %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_random_stall();
    int k;
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.out_ready = ($urandom % 3) != 0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.s = 4'($urandom);
      tick();
      tests++; if (sb.size() > 2) begin fails++; $display("FAIL occupancy[%0d]: got %0d want <=2", i, sb.size()); end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 10) begin tick(); k++; end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL stall_drain: %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ba [3] = '{16'h0001, 16'h000A, 16'hF0F0};
    logic [W-1:0] bb [3] = '{16'h0002, 16'h0003, 16'h0FF0};
    logic [3:0]   bs [3] = '{4'd0, 4'd1, 4'd6};
    int idx = 0;
    int k;
    logic acc;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      set_beat(ba[idx], bb[idx], bs[idx]);
      #1;
      if (cyc >= 2) begin
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b want 0", cyc, bus.in_ready); end
        tests++;
        if (bus.out_valid !== 1'b1 || bus.yout !== 16'h0003) begin
          fails++; $display("FAIL bp_hold[%0d]: got valid %b yout %h want 1 0003", cyc, bus.out_valid, bus.yout);
        end
      end
      acc = bus.in_ready;
      tick();
      if (acc && idx < 2) idx++;
    end
    tests++; if (idx != 2) begin fails++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    bus.out_ready = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_full_accept: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 10) begin tick(); k++; end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL bp_drain: %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_enable();
    res_t saved;
    int k;
    bus.out_ready = 1'b0;
    set_beat(16'h1234, 16'h00FF, 4'd4); tick();
    set_beat(16'h1200, 16'h0034, 4'd5); tick();
    bus.in_valid = 1'b0;
    saved = observed();
    tests++; if (saved.y !== 16'h0034) begin fails++; $display("FAIL en_prefill: got %h want 0034", saved.y); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus.a = W'($urandom); bus.b = W'($urandom); bus.s = 4'($urandom);
      #1;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL en_ready[%0d]: got %b want 0", i, bus.in_ready); end
      tick();
      tests++;
      if (observed() !== saved || bus.out_valid !== 1'b1 || dut.s1_valid !== 1'b1) begin
        fails++;
        $display("FAIL en_freeze[%0d]: got %h v%b s1 %b want %h v1 s1 1", i, observed(), bus.out_valid, dut.s1_valid, saved);
      end
    end
    en = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 10) begin tick(); k++; end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL en_drain: %0d outstanding want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    set_beat(16'h0100, 16'h0200, 4'd0); tick();
    set_beat(16'h0005, 16'h0000, 4'd2); tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    tick();
    tests++;
    if (bus.out_valid !== 1'b0 || observed() !== '0 || dut.s1_valid !== 1'b0) begin
      fails++; $display("FAIL rst_mid: got valid %b out %h s1 %b want 0 0 0", bus.out_valid, observed(), dut.s1_valid);
    end
    rst = 1'b0; bus.out_ready = 1'b1;
    set_beat(16'h0041, 16'h0000, 4'd2);
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_early: got %b want 0", bus.out_valid); end
    tick();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.yout !== 16'h0042) begin
      fails++; $display("FAIL rst_mid_first: got valid %b yout %h want 1 0042", bus.out_valid, bus.yout);
    end
    tick();
  endtask

  task automatic test_sleep();
    logic on;
    int k;
`ifdef ALU_LP_SLEEP_EN
    on = 1'b1;
`else
    on = 1'b0;
`endif
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      tests++; if (sleep !== 1'b0) begin fails++; $display("FAIL sleep_early[%0d]: got %b want 0", i, sleep); end
    end
    en = 1'b0;
    repeat (3) tick();
    tests++; if (sleep !== 1'b0) begin fails++; $display("FAIL sleep_hold: got %b want 0", sleep); end
    en = 1'b1;
    tick();
    tests++; if (sleep !== 1'b0) begin fails++; $display("FAIL sleep_edge3: got %b want 0", sleep); end
    for (int i = 4; i <= 6; i++) begin
      tick();
      tests++; if (sleep !== on) begin fails++; $display("FAIL sleep_on[%0d]: got %b want %b", i, sleep, on); end
    end
    set_beat(16'h0007, 16'h0000, 4'd13);
    #1;
    tests++; if (sleep !== on) begin fails++; $display("FAIL sleep_pre_wake: got %b want %b", sleep, on); end
    tick();
    bus.in_valid = 1'b0;
    tests++; if (sleep !== 1'b0) begin fails++; $display("FAIL sleep_wake: got %b want 0", sleep); end
    k = 0;
    while (sb.size() != 0 && k < 10) begin tick(); k++; end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL sleep_drain: %0d outstanding want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_random_stall();
    test_sleep();
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL final_sb: %0d outstanding want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
